// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-cache main-memory arbiter: FSM and owner
// encodings, default widths and the round-robin pick rule.
package mem_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH  = 28;
    localparam int DEF_BLOCK_WIDTH = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // A lone requester always wins; on contention the one not served last wins.
    function automatic owner_t rr_pick(input logic req_i, input logic req_d, input owner_t last_owner);
        owner_t pick;
        if (req_i && req_d) begin
            pick = (last_owner == OWN_I) ? OWN_D : OWN_I;
        end else if (req_d) begin
            pick = OWN_D;
        end else begin
            pick = OWN_I;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-requester round-robin grant; remembers who was served last and only
// advances when the caller actually accepts a grant.
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic srst,
    input  logic req_i,
    input  logic req_d,
    input  logic advance,
    output logic grant_d,
    output logic grant_valid
);

    owner_t last_owner_reg;
    owner_t last_owner_next;
    owner_t winner;

    always_comb begin
        winner          = rr_pick(req_i, req_d, last_owner_reg);
        last_owner_next = last_owner_reg;
        if (advance && (req_i || req_d)) begin
            last_owner_next = winner;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            last_owner_reg <= OWN_I;
        end else begin
            last_owner_reg <= last_owner_next;
        end
    end

    assign grant_d     = (winner == OWN_D);
    assign grant_valid = req_i | req_d;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates i_cache refills and d_cache refills/write-backs onto the single
// main-memory block port, one transaction at a time, using busywait handshakes.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int BLOCK_WIDTH = DEF_BLOCK_WIDTH
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   I_READ,
    input  logic [ADDR_WIDTH-1:0]  I_ADDRESS,
    output logic [BLOCK_WIDTH-1:0] I_READDATA,
    output logic                   I_BUSYWAIT,
    input  logic                   D_READ,
    input  logic                   D_WRITE,
    input  logic [ADDR_WIDTH-1:0]  D_ADDRESS,
    input  logic [BLOCK_WIDTH-1:0] D_WRITEDATA,
    output logic [BLOCK_WIDTH-1:0] D_READDATA,
    output logic                   D_BUSYWAIT,
    output logic                   MEM_READ,
    output logic                   MEM_WRITE,
    output logic [ADDR_WIDTH-1:0]  MEM_ADDRESS,
    output logic [BLOCK_WIDTH-1:0] MEM_WRITEDATA,
    input  logic [BLOCK_WIDTH-1:0] MEM_READDATA,
    input  logic                   MEM_BUSYWAIT
);

    arb_state_t state_reg;
    arb_state_t state_next;
    owner_t     owner_reg;

    logic                   mem_read_reg;
    logic                   mem_write_reg;
    logic [ADDR_WIDTH-1:0]  mem_address_reg;
    logic [BLOCK_WIDTH-1:0] mem_writedata_reg;
    logic [BLOCK_WIDTH-1:0] i_readdata_reg;
    logic [BLOCK_WIDTH-1:0] d_readdata_reg;

    logic req_i;
    logic req_d;
    logic grant_d;
    logic grant_valid;
    logic grant_take;
    logic busy_end;

    assign req_i = I_READ;
    assign req_d = D_READ | D_WRITE;

    rr_arbiter2 u_rr (
        .clk         (CLK),
        .srst        (RESET),
        .req_i       (req_i),
        .req_d       (req_d),
        .advance     (grant_take),
        .grant_d     (grant_d),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        grant_take = 1'b0;
        busy_end   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_next = ST_BUSY;
                    grant_take = 1'b1;
                end
            end
            ST_BUSY: begin
                if (!MEM_BUSYWAIT) begin
                    state_next = ST_DONE;
                    busy_end   = 1'b1;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Transaction registers: loaded on grant, strobes held until memory finishes.
    // A D request with D_WRITE high is a write-back even if D_READ is also high.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            owner_reg         <= OWN_I;
            mem_read_reg      <= 1'b0;
            mem_write_reg     <= 1'b0;
            mem_address_reg   <= '0;
            mem_writedata_reg <= '0;
            i_readdata_reg    <= '0;
            d_readdata_reg    <= '0;
        end else if (grant_take) begin
            if (grant_d) begin
                owner_reg         <= OWN_D;
                mem_address_reg   <= D_ADDRESS;
                mem_writedata_reg <= D_WRITEDATA;
                mem_write_reg     <= D_WRITE;
                mem_read_reg      <= ~D_WRITE;
            end else begin
                owner_reg         <= OWN_I;
                mem_address_reg   <= I_ADDRESS;
                mem_writedata_reg <= '0;
                mem_write_reg     <= 1'b0;
                mem_read_reg      <= 1'b1;
            end
        end else if (busy_end) begin
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            if (mem_read_reg) begin
                if (owner_reg == OWN_D) begin
                    d_readdata_reg <= MEM_READDATA;
                end else begin
                    i_readdata_reg <= MEM_READDATA;
                end
            end
        end
    end

    // Busywait drops only in the owner's single DONE cycle.
    assign I_BUSYWAIT = req_i && !((state_reg == ST_DONE) && (owner_reg == OWN_I));
    assign D_BUSYWAIT = req_d && !((state_reg == ST_DONE) && (owner_reg == OWN_D));

    assign MEM_READ      = mem_read_reg;
    assign MEM_WRITE     = mem_write_reg;
    assign MEM_ADDRESS   = mem_address_reg;
    assign MEM_WRITEDATA = mem_writedata_reg;
    assign I_READDATA    = i_readdata_reg;
    assign D_READDATA    = d_readdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: cache drivers push expected responses,
// a negedge monitor checks grants, memory-port behaviour and completions.
module tb_mem_arbiter;

    localparam int AW  = 28;
    localparam int BW  = 128;
    localparam int TMO = 300;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          I_READ = 1'b0;
    logic [AW-1:0] I_ADDRESS = '0;
    logic [BW-1:0] I_READDATA;
    logic          I_BUSYWAIT;
    logic          D_READ = 1'b0;
    logic          D_WRITE = 1'b0;
    logic [AW-1:0] D_ADDRESS = '0;
    logic [BW-1:0] D_WRITEDATA = '0;
    logic [BW-1:0] D_READDATA;
    logic          D_BUSYWAIT;
    logic          MEM_READ;
    logic          MEM_WRITE;
    logic [AW-1:0] MEM_ADDRESS;
    logic [BW-1:0] MEM_WRITEDATA;
    logic [BW-1:0] MEM_READDATA = '0;
    logic          MEM_BUSYWAIT = 1'b1;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .I_READ        (I_READ),
        .I_ADDRESS     (I_ADDRESS),
        .I_READDATA    (I_READDATA),
        .I_BUSYWAIT    (I_BUSYWAIT),
        .D_READ        (D_READ),
        .D_WRITE       (D_WRITE),
        .D_ADDRESS     (D_ADDRESS),
        .D_WRITEDATA   (D_WRITEDATA),
        .D_READDATA    (D_READDATA),
        .D_BUSYWAIT    (D_BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    typedef struct {
        logic          is_wr;
        logic [BW-1:0] data;
    } exp_t;

    logic [BW-1:0] i_exp [$];
    exp_t          d_exp [$];
    logic [BW-1:0] ref_mem  [logic [AW-1:0]];
    logic [BW-1:0] phys_mem [logic [AW-1:0]];

    int lat_min = 1;
    int lat_max = 1;
    int cur_lat = 1;
    int mem_cnt = 0;

    function automatic logic [BW-1:0] init_data(input logic [AW-1:0] a);
        return {a ^ 28'h5A3C1E7, 4'h1, a ^ 28'h0F0F0F0, 4'h2, ~a, 4'h3, a, 4'h4};
    endfunction

    function automatic logic [BW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_data(a);
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Main-memory model: busy for cur_lat strobe cycles, commits writes on completion.
    always @(negedge CLK) begin
        if (RESET || !(MEM_READ || MEM_WRITE)) begin
            mem_cnt      = 0;
            MEM_BUSYWAIT = 1'b1;
            MEM_READDATA = {4{$urandom}};
        end else begin
            if (mem_cnt == 0) cur_lat = $urandom_range(lat_max, lat_min);
            mem_cnt++;
            MEM_READDATA = phys_mem.exists(MEM_ADDRESS) ? phys_mem[MEM_ADDRESS] : init_data(MEM_ADDRESS);
            MEM_BUSYWAIT = (mem_cnt < cur_lat);
            if (!MEM_BUSYWAIT && MEM_WRITE) phys_mem[MEM_ADDRESS] = MEM_WRITEDATA;
        end
    end

    // Stimulus legality: no simultaneous D read/write, no request dropped while stalled.
    logic a_i_req = 1'b0, a_i_bw = 1'b0, a_d_req = 1'b0, a_d_bw = 1'b0;
    always @(negedge CLK) begin
        if (!RESET) begin
            assert (!(D_READ && D_WRITE)) else $error("D_READ and D_WRITE both high");
            assert (!(a_i_req && a_i_bw) || I_READ) else $error("I_READ dropped while stalled");
            assert (!(a_d_req && a_d_bw) || (D_READ || D_WRITE)) else $error("D request dropped while stalled");
        end
        a_i_req = I_READ;
        a_i_bw  = I_BUSYWAIT;
        a_d_req = D_READ | D_WRITE;
        a_d_bw  = D_BUSYWAIT;
    end

    // Monitor: the I region has address bit 27 clear, the D region has it set.
    logic          last_served, p_strobe, p_i_req, p_d_req, p_d_wr;
    logic [AW-1:0] p_i_addr, p_d_addr, cur_addr;
    logic [BW-1:0] p_d_wd, cur_wd, i_last, d_last;
    logic          cur_owner, cur_rd, cur_wr, expect_b2b;
    int            cur_len, idle_cnt;

    always @(negedge CLK) begin : mon
        logic strobe;
        logic exp_owner;
        exp_t e;
        strobe = MEM_READ | MEM_WRITE;
        if (RESET) begin
            last_served = 1'b0;
            p_strobe    = 1'b0;
            cur_len     = 0;
            idle_cnt    = 0;
            expect_b2b  = 1'b0;
            cur_owner   = 1'b0;
            i_last      = '0;
            d_last      = '0;
        end else begin
            if (strobe) chk("strobe_excl", MEM_READ & MEM_WRITE, 0);
            if (strobe && !p_strobe) begin
                if (!p_i_req && !p_d_req) chk("spurious_grant", 1, 0);
                exp_owner   = (p_i_req && p_d_req) ? !last_served : p_d_req;
                last_served = exp_owner;
                chk("grant_owner", MEM_ADDRESS[AW-1], exp_owner);
                if (expect_b2b) chk("b2b_gap", idle_cnt, 2);
                if (exp_owner) begin
                    chk("grant_d_write", MEM_WRITE, p_d_wr);
                    chk("grant_d_addr", MEM_ADDRESS, p_d_addr);
                    if (p_d_wr) chk("grant_d_wdata", MEM_WRITEDATA, p_d_wd);
                end else begin
                    chk("grant_i_read", MEM_READ, 1);
                    chk("grant_i_addr", MEM_ADDRESS, p_i_addr);
                end
                cur_owner  = exp_owner;
                cur_rd     = MEM_READ;
                cur_wr     = MEM_WRITE;
                cur_addr   = MEM_ADDRESS;
                cur_wd     = MEM_WRITEDATA;
                cur_len    = 1;
                expect_b2b = 1'b0;
            end else if (strobe) begin
                chk("strobe_hold", {MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA},
                    {cur_rd, cur_wr, cur_addr, cur_wd});
                cur_len++;
            end
            if (strobe) idle_cnt = 0;
            else idle_cnt++;

            if (I_READ && !I_BUSYWAIT) begin
                chk("i_done_timing", {p_strobe, strobe, cur_owner}, 3'b100);
                chk("i_busy_len", cur_len, cur_lat);
                if (i_exp.size() == 0) chk("i_unexpected_done", 1, 0);
                else begin
                    i_last = i_exp.pop_front();
                    chk("i_readdata", I_READDATA, i_last);
                end
                chk("d_readdata_kept", D_READDATA, d_last);
                expect_b2b = D_READ | D_WRITE;
            end
            if ((D_READ || D_WRITE) && !D_BUSYWAIT) begin
                chk("d_done_timing", {p_strobe, strobe, cur_owner}, 3'b101);
                chk("d_busy_len", cur_len, cur_lat);
                if (d_exp.size() == 0) chk("d_unexpected_done", 1, 0);
                else begin
                    e = d_exp.pop_front();
                    if (!e.is_wr) d_last = e.data;
                    chk("d_readdata", D_READDATA, d_last);
                end
                chk("i_readdata_kept", I_READDATA, i_last);
                expect_b2b = I_READ;
            end
            p_strobe = strobe;
        end
        p_i_req  = I_READ;
        p_i_addr = I_ADDRESS;
        p_d_req  = D_READ | D_WRITE;
        p_d_wr   = D_WRITE;
        p_d_addr = D_ADDRESS;
        p_d_wd   = D_WRITEDATA;
    end

    task automatic i_txn(input logic [AW-1:0] a, input int gap, input int exp_cyc);
        int n;
        repeat (gap) @(posedge CLK);
        #1;
        I_ADDRESS = a;
        I_READ    = 1'b1;
        i_exp.push_back(ref_read(a));
        n = 0;
        do begin @(negedge CLK); n++; end while (I_BUSYWAIT && n < TMO);
        if (I_BUSYWAIT) chk("i_timeout", 1, 0);
        else if (exp_cyc > 0) chk("i_latency", n, exp_cyc);
        @(posedge CLK);
        #1 I_READ = 1'b0;
    endtask

    task automatic d_txn(input logic [AW-1:0] a, input logic wr, input logic [BW-1:0] wd, input int gap);
        int n;
        exp_t e;
        repeat (gap) @(posedge CLK);
        #1;
        D_ADDRESS   = a;
        D_WRITEDATA = wd;
        D_WRITE     = wr;
        D_READ      = !wr;
        e.is_wr = wr;
        e.data  = wr ? '0 : ref_read(a);
        if (wr) ref_mem[a] = wd;
        d_exp.push_back(e);
        n = 0;
        do begin @(negedge CLK); n++; end while (D_BUSYWAIT && n < TMO);
        if (D_BUSYWAIT) chk("d_timeout", 1, 0);
        @(posedge CLK);
        #1;
        D_READ  = 1'b0;
        D_WRITE = 1'b0;
    endtask

    function automatic logic [BW-1:0] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [BW-1:0] blk;
        blk = 128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF;
        ref_mem[28'h0000040]  = blk;
        phys_mem[28'h0000040] = blk;

        // Reset held with I_READ pending, then the 5-cycle single I read.
        lat_min = 5; lat_max = 5;
        RESET = 1'b1; I_ADDRESS = 28'h0000040; I_READ = 1'b1;
        i_exp.push_back(ref_read(28'h0000040));
        repeat (2) begin
            @(negedge CLK);
            chk("reset_strobes", {MEM_READ, MEM_WRITE}, 2'b00);
            chk("reset_readdata", {I_READDATA, D_READDATA}, 256'h0);
            chk("reset_mem_regs", {MEM_ADDRESS, MEM_WRITEDATA}, 0);
        end
        #1 RESET = 1'b0;
        @(negedge CLK);
        chk("mem_read_after_reset", MEM_READ, 1);
        n = 1;
        while (I_BUSYWAIT && n < TMO) begin @(negedge CLK); n++; end
        chk("i_first_latency", n, 6);
        @(posedge CLK);
        #1 I_READ = 1'b0;

        // Reset three cycles into a long D read: strobe drops, nothing captured.
        lat_min = 10; lat_max = 10;
        @(posedge CLK);
        #1 D_ADDRESS = 28'h8000100; D_READ = 1'b1;
        n = 0;
        do begin @(negedge CLK); n++; end while (!MEM_READ && n < TMO);
        repeat (2) @(negedge CLK);
        #1 RESET = 1'b1; D_READ = 1'b0;
        @(negedge CLK);
        chk("abort_mem_read", MEM_READ, 0);
        chk("abort_d_readdata", D_READDATA, 0);
        chk("abort_state", dut.state_reg, 2'd0);
        #1 RESET = 1'b0;
        @(negedge CLK);
        chk("idle_after_abort", {MEM_READ, MEM_WRITE}, 2'b00);
        @(posedge CLK);

        // Simultaneous I read and D write with last owner I: D goes first.
        lat_min = 3; lat_max = 3;
        fork
            i_txn(28'h0000080, 0, 0);
            d_txn(28'h8000010, 1'b1, rand_block(), 0);
        join

        // Fairness: both keep re-requesting, grants alternate D, I, D, I.
        lat_min = 2; lat_max = 2;
        fork
            repeat (2) i_txn(28'($urandom_range(0, 63)), 0, 0);
            repeat (2) d_txn(28'h8000010, 1'b0, '0, 0);
        join

        // Zero-wait memory: isolated read latency, then back-to-back traffic.
        lat_min = 1; lat_max = 1;
        i_txn(28'h0000100, 1, 3);
        fork
            repeat (3) i_txn(28'($urandom_range(0, 63)), 0, 0);
            repeat (3) d_txn(28'h8000000 | 28'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), rand_block(), 0);
        join

        // Randomized traffic with variable memory latency.
        lat_min = 1; lat_max = 6;
        fork
            repeat (40) i_txn(28'($urandom_range(0, 63)), $urandom_range(0, 3), 0);
            repeat (40) d_txn(28'h8000000 | 28'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                              rand_block(), $urandom_range(0, 3));
        join

        repeat (4) @(negedge CLK);
        chk("i_queue_empty", i_exp.size(), 0);
        chk("d_queue_empty", d_exp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
